collision_issue_ctrl: RTL and testbench

Scheduler that sits between the G-code segment source and `CollisionDetect`. It buffers incoming voxel line segments in a FIFO and issues them to the detector at a programmable minimum spacing. It collects the detector's `out_val`/`lineID` hits into counters and detects the end of a job. It replaces bench-style hard-coded pacing with a reusable, back-pressured controller.

---
 rtl/collision_issue_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_collision_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_issue_ctrl.sv
// -----------------------------------------------------------------------------
// collision_issue_ctrl
//
// Paces voxel line segments from the G-code segment source into the
// CollisionDetect block. Incoming segments are buffered in a small FIFO and
// issued to the detector no closer together than GAP cycles. Detector hits are
// forwarded and counted, and the end of a job is signalled DRAIN+1 cycles after
// the segment flagged as last has been issued.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..64)
//   GAP    minimum cycles between detector issues (1..15)
//   DRAIN  cycles waited after the last issue before done (1..255)
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   s_val/s_rdy        segment source handshake
//   s_seg, s_last      segment {x1,y1,z1,x2,y2,z2} and end-of-job marker
//   cd_in_val, cd_seg  issue strobe and segment to CollisionDetect
//   cd_out_val         detector hit strobe
//   cd_lineID          detector line id of the hit
//   hit_val, hit_line  registered copy of the latest hit
//   first_line         line id of the first hit of the current job
//   hit_cnt            saturating hit counter for the current job
//   issue_cnt          wrapping count of issued segments for the current job
//   busy               controller is not idle
//   done               one-cycle end-of-job pulse
// -----------------------------------------------------------------------------
module collision_issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int GAP   = 2,
  parameter int DRAIN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_val,
  output logic        s_rdy,
  input  logic [47:0] s_seg,
  input  logic        s_last,
  output logic        cd_in_val,
  output logic [47:0] cd_seg,
  input  logic        cd_out_val,
  input  logic [7:0]  cd_lineID,
  output logic        hit_val,
  output logic [7:0]  hit_line,
  output logic [7:0]  first_line,
  output logic [15:0] hit_cnt,
  output logic [15:0] issue_cnt,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [48:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [3:0]  r_pace;
  logic [7:0]  r_drain_cnt;
  logic        r_last_seen;
  logic        r_first_vld;
  logic        r_cd_in_val;
  logic [47:0] r_cd_seg;
  logic [15:0] r_issue_cnt;
  logic        r_done;
  logic        r_hit_val;
  logic [7:0]  r_hit_line;
  logic [7:0]  r_first_line;
  logic [15:0] r_hit_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_rdy;
  logic        w_push;
  logic        w_start;
  logic        w_issue;
  logic [48:0] w_head;
  logic [15:0] w_hit_base;
  logic        w_fv_base;

  // FIFO status, handshake and issue decode from registered state
  always_comb begin
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_empty = (r_wr_ptr == r_rd_ptr);
    // reset gates ready so nothing is taken while the block is held in reset
    w_rdy   = !reset && !w_full && !r_last_seen &&
              ((r_state == ST_IDLE) || (r_state == ST_RUN));
    w_push  = s_val && w_rdy;
    w_start = (r_state == ST_IDLE) && w_push;
    w_issue = (r_state == ST_RUN) && !w_empty && (r_pace == 4'd0);
    w_head  = r_mem[r_rd_ptr[AW-1:0]];
    // a job start clears the per-job hit tracking before a same-edge hit lands
    if (w_start) begin
      w_hit_base = 16'd0;
      w_fv_base  = 1'b0;
    end else begin
      w_hit_base = r_hit_cnt;
      w_fv_base  = r_first_vld;
    end
  end

  // FIFO storage write port (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s_last, s_seg};
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Job FSM with issue pacing, issue outputs and end-of-job pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pace      <= 4'd0;
      r_drain_cnt <= 8'd0;
      r_last_seen <= 1'b0;
      r_cd_in_val <= 1'b0;
      r_cd_seg    <= 48'd0;
      r_issue_cnt <= 16'd0;
      r_done      <= 1'b0;
    end else begin
      r_cd_in_val <= 1'b0;
      r_done      <= 1'b0;
      // pace counts down to zero between issues; zero means the detector may take one
      if (w_issue) begin
        r_cd_in_val <= 1'b1;
        r_cd_seg    <= w_head[47:0];
        r_issue_cnt <= r_issue_cnt + 16'd1;
        r_pace      <= 4'(GAP - 1);
      end else if (r_pace != 4'd0) begin
        r_pace <= r_pace - 4'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_RUN;
            r_issue_cnt <= 16'd0;
            // a one-segment job can be flagged last on its very first accept
            r_last_seen <= s_last;
          end
        end
        ST_RUN: begin
          if (w_push && s_last) begin
            r_last_seen <= 1'b1;
          end
          if (w_issue && w_head[48]) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 8'(DRAIN);
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - 8'd1;
          if (r_drain_cnt == 8'd1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // done rises as we return to IDLE, which also re-opens the source
          r_done      <= 1'b1;
          r_last_seen <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Detector hit forwarding and per-job hit statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_val    <= 1'b0;
      r_hit_line   <= 8'd0;
      r_first_line <= 8'd0;
      r_first_vld  <= 1'b0;
      r_hit_cnt    <= 16'd0;
    end else begin
      r_hit_val <= cd_out_val;
      if (cd_out_val) begin
        r_hit_line  <= cd_lineID;
        r_hit_cnt   <= (w_hit_base == 16'hFFFF) ? 16'hFFFF : (w_hit_base + 16'd1);
        r_first_vld <= 1'b1;
        if (!w_fv_base) begin
          r_first_line <= cd_lineID;
        end
      end else begin
        r_hit_cnt   <= w_hit_base;
        r_first_vld <= w_fv_base;
      end
    end
  end

  assign s_rdy      = w_rdy;
  assign busy       = (r_state != ST_IDLE);
  assign cd_in_val  = r_cd_in_val;
  assign cd_seg     = r_cd_seg;
  assign issue_cnt  = r_issue_cnt;
  assign done       = r_done;
  assign hit_val    = r_hit_val;
  assign hit_line   = r_hit_line;
  assign first_line = r_first_line;
  assign hit_cnt    = r_hit_cnt;

endmodule

// File: tb/tb_collision_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collision_issue_ctrl
//
// Self-checking bench for collision_issue_ctrl (DEPTH=8, GAP=2, DRAIN=16).
// A timeline reference model keeps accepted segments in a queue and derives
// issue times from the rules "at most one issue per GAP edges, never before
// the edge after acceptance" and "done DRAIN+1 edges after the last issue".
// Every cycle the DUT outputs are compared to the model; directed scenarios add
// checks against fixed expected numbers.
// -----------------------------------------------------------------------------
module tb_collision_issue_ctrl;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_val;
  logic        s_rdy;
  logic [47:0] s_seg;
  logic        s_last;
  logic        cd_in_val;
  logic [47:0] cd_seg;
  logic        cd_out_val;
  logic [7:0]  cd_lineID;
  logic        hit_val;
  logic [7:0]  hit_line;
  logic [7:0]  first_line;
  logic [15:0] hit_cnt;
  logic [15:0] issue_cnt;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  collision_issue_ctrl #(.DEPTH(DEPTH), .GAP(GAP), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .s_val(s_val), .s_rdy(s_rdy), .s_seg(s_seg),
    .s_last(s_last), .cd_in_val(cd_in_val), .cd_seg(cd_seg),
    .cd_out_val(cd_out_val), .cd_lineID(cd_lineID), .hit_val(hit_val),
    .hit_line(hit_line), .first_line(first_line), .hit_cnt(hit_cnt),
    .issue_cnt(issue_cnt), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [48:0] m_q[$];
  int          edge_n       = 0;
  int          m_last_issue = -1000;
  int          m_done_edge  = -1;
  bit          m_active     = 1'b0;
  bit          m_last_seen  = 1'b0;
  bit          m_fv         = 1'b0;
  bit          m_accepted   = 1'b0;
  logic        e_cd_val, e_hit_val, e_done;
  logic [47:0] e_cd_seg;
  logic [7:0]  e_hit_line, e_first;
  logic [15:0] e_hit_cnt, e_issue_cnt;

  // observations of the DUT, for directed checks
  int          obs_issue_edge[$];
  logic [47:0] obs_issue_seg[$];
  logic [7:0]  obs_hits[$];
  int          acc_edge[$];
  int          obs_done_edge = -1;
  logic [15:0] issue_at_done;
  logic        busy_at_done;

  function automatic bit m_rdy();
    return !reset && (m_q.size() < DEPTH) && !m_last_seen;
  endfunction

  function automatic logic [47:0] rand_seg();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic model_edge();
    logic [48:0] ent;
    bit acc, start;
    edge_n++;
    m_accepted = 1'b0;
    if (reset) begin
      m_q.delete();
      m_active = 1'b0; m_last_seen = 1'b0; m_fv = 1'b0;
      m_last_issue = -1000; m_done_edge = -1;
      e_cd_val = 1'b0; e_cd_seg = 48'd0; e_hit_val = 1'b0; e_hit_line = 8'd0;
      e_first = 8'd0; e_hit_cnt = 16'd0; e_issue_cnt = 16'd0; e_done = 1'b0;
    end else begin
      acc   = s_val && (m_q.size() < DEPTH) && !m_last_seen;
      start = acc && !m_active;
      e_cd_val = 1'b0;
      if (m_active && (m_q.size() > 0) && ((edge_n - m_last_issue) >= GAP)) begin
        ent = m_q.pop_front();
        e_cd_val = 1'b1;
        e_cd_seg = ent[47:0];
        e_issue_cnt = e_issue_cnt + 16'd1;
        m_last_issue = edge_n;
        if (ent[48]) m_done_edge = edge_n + DRAIN + 1;
      end
      e_done = (edge_n == m_done_edge);
      if (e_done) begin
        m_active = 1'b0;
        m_last_seen = 1'b0;
      end
      if (start) begin
        m_active = 1'b1; e_issue_cnt = 16'd0; e_hit_cnt = 16'd0; m_fv = 1'b0;
      end
      if (acc) begin
        m_q.push_back({s_last, s_seg});
        if (s_last) m_last_seen = 1'b1;
        m_accepted = 1'b1;
        acc_edge.push_back(edge_n);
      end
      e_hit_val = cd_out_val;
      if (cd_out_val) begin
        e_hit_line = cd_lineID;
        if (e_hit_cnt != 16'hFFFF) e_hit_cnt = e_hit_cnt + 16'd1;
        if (!m_fv) begin
          e_first = cd_lineID;
          m_fv = 1'b1;
        end
      end
    end
  endtask

  // one clock: model update at the edge, compare on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("s_rdy",      64'(s_rdy),      64'(m_rdy()));
    check_eq("cd_in_val",  64'(cd_in_val),  64'(e_cd_val));
    check_eq("cd_seg",     64'(cd_seg),     64'(e_cd_seg));
    check_eq("hit_val",    64'(hit_val),    64'(e_hit_val));
    check_eq("hit_line",   64'(hit_line),   64'(e_hit_line));
    check_eq("first_line", 64'(first_line), 64'(e_first));
    check_eq("hit_cnt",    64'(hit_cnt),    64'(e_hit_cnt));
    check_eq("issue_cnt",  64'(issue_cnt),  64'(e_issue_cnt));
    check_eq("busy",       64'(busy),       64'(m_active));
    check_eq("done",       64'(done),       64'(e_done));
    if (cd_in_val) begin
      obs_issue_edge.push_back(edge_n);
      obs_issue_seg.push_back(cd_seg);
    end
    if (hit_val) obs_hits.push_back(hit_line);
    if (done) begin
      obs_done_edge = edge_n;
      issue_at_done = issue_cnt;
      busy_at_done  = busy;
    end
  endtask

  task automatic wait_done(input string tag, input bit rnd_hits);
    int k = 0;
    obs_done_edge = -1;
    while (obs_done_edge < 0 && k < 200) begin
      cd_out_val = rnd_hits ? ($urandom_range(0, 3) == 0) : 1'b0;
      cd_lineID  = 8'($urandom_range(0, 255));
      step();
      k++;
    end
    cd_out_val = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(obs_done_edge >= 0), 64'd1);
  endtask

  task automatic clear_obs();
    obs_issue_edge.delete();
    obs_issue_seg.delete();
    obs_hits.delete();
    acc_edge.delete();
    obs_done_edge = -1;
  endtask

  initial begin
    logic [47:0] segs[$];
    logic [7:0]  hl[3];
    int idx, k, low, n, pause;

    reset = 1'b1; s_val = 1'b0; s_seg = 48'd0; s_last = 1'b0;
    cd_out_val = 1'b0; cd_lineID = 8'd0;
    repeat (3) step();
    check_eq("rst_busy",      64'(busy),      64'd0);
    check_eq("rst_cd_in_val", 64'(cd_in_val), 64'd0);
    check_eq("rst_hit_cnt",   64'(hit_cnt),   64'd0);
    reset = 1'b0;
    step();
    check_eq("rdy_after_rst", 64'(s_rdy), 64'd1);

    // single job of 5, then a 6th segment held while the job drains
    clear_obs(); segs.delete();
    for (int i = 0; i < 6; i++) segs.push_back(rand_seg());
    idx = 0; k = 0;
    while (idx < 6 && k < 80) begin
      s_val = 1'b1; s_seg = segs[idx]; s_last = (idx >= 4);
      step();
      if (m_accepted) idx++;
      k++;
    end
    s_val = 1'b0; s_last = 1'b0;
    check_eq("a_accepts", 64'(idx), 64'd6);
    check_eq("a_issue_n", 64'(obs_issue_edge.size()), 64'd5);
    if (obs_issue_edge.size() >= 5 && acc_edge.size() >= 6) begin
      for (int i = 0; i < 5; i++) begin
        check_eq("a_issue_ofs", 64'(obs_issue_edge[i] - acc_edge[0]), 64'(2 * i + 1));
        check_eq("a_issue_seg", 64'(obs_issue_seg[i]), 64'(segs[i]));
      end
      check_eq("a_done_ofs", 64'(obs_done_edge - obs_issue_edge[4]), 64'd17);
      check_eq("a_stall_accept", 64'(acc_edge[5] - obs_done_edge), 64'd1);
    end
    check_eq("a_issue_cnt", 64'(issue_at_done), 64'd5);
    check_eq("a_busy_after", 64'(busy_at_done), 64'd0);
    wait_done("a2", 1'b0);

    // back-pressure: 20 segments offered continuously
    clear_obs(); segs.delete();
    for (int i = 0; i < 20; i++) segs.push_back(rand_seg());
    idx = 0; k = 0; low = 0;
    while (idx < 20 && k < 200) begin
      s_val = 1'b1; s_seg = segs[idx]; s_last = (idx == 19);
      step();
      if (m_accepted) idx++;
      if (!s_rdy) low++;
      k++;
    end
    s_val = 1'b0; s_last = 1'b0;
    wait_done("bp", 1'b0);
    check_eq("bp_rdy_dropped", 64'(low > 0), 64'd1);
    check_eq("bp_issue_n", 64'(obs_issue_seg.size()), 64'd20);
    if (obs_issue_seg.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check_eq("bp_order", 64'(obs_issue_seg[i]), 64'(segs[i]));
        if (i > 0) check_eq("bp_spacing", 64'(obs_issue_edge[i] - obs_issue_edge[i-1]), 64'(GAP));
      end
    end

    // hits 0x03, 0x07, 0x03 during a job; a new job clears the count
    clear_obs();
    hl[0] = 8'h03; hl[1] = 8'h07; hl[2] = 8'h03;
    s_val = 1'b1; s_seg = rand_seg(); s_last = 1'b1;
    step();
    s_val = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cd_out_val = 1'b1; cd_lineID = hl[i];
      step();
      cd_out_val = 1'b0;
      step();
    end
    check_eq("hit_n", 64'(obs_hits.size()), 64'd3);
    if (obs_hits.size() == 3) begin
      for (int i = 0; i < 3; i++) check_eq("hit_line_seq", 64'(obs_hits[i]), 64'(hl[i]));
    end
    check_eq("hit_cnt3", 64'(hit_cnt), 64'd3);
    check_eq("first_line3", 64'(first_line), 64'h03);
    wait_done("hit", 1'b0);
    s_val = 1'b1; s_seg = rand_seg(); s_last = 1'b1;
    step();
    s_val = 1'b0; s_last = 1'b0;
    check_eq("hit_cnt_newjob", 64'(hit_cnt), 64'd0);
    wait_done("hit2", 1'b0);

    // hit on the same edge as the job start
    s_val = 1'b1; s_seg = rand_seg(); s_last = 1'b1;
    cd_out_val = 1'b1; cd_lineID = 8'h2A;
    step();
    s_val = 1'b0; s_last = 1'b0; cd_out_val = 1'b0;
    check_eq("coinc_hit_cnt", 64'(hit_cnt), 64'd1);
    check_eq("coinc_first", 64'(first_line), 64'h2A);
    wait_done("coinc", 1'b0);

    // reset with entries still buffered
    for (int i = 0; i < 8; i++) begin
      s_val = 1'b1; s_seg = rand_seg(); s_last = 1'b0;
      step();
    end
    s_val = 1'b0; reset = 1'b1;
    step();
    check_eq("mid_rst_cd_in_val", 64'(cd_in_val), 64'd0);
    check_eq("mid_rst_cd_seg",    64'(cd_seg),    64'd0);
    check_eq("mid_rst_issue_cnt", 64'(issue_cnt), 64'd0);
    check_eq("mid_rst_busy",      64'(busy),      64'd0);
    check_eq("mid_rst_hit_cnt",   64'(hit_cnt),   64'd0);
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      cd_out_val = (i == 5); cd_lineID = 8'h55;
      step();
    end
    cd_out_val = 1'b0;
    check_eq("mid_rst_no_issue", 64'(obs_issue_edge.size()), 64'd0);
    check_eq("mid_rst_hit_fwd", 64'(hit_cnt), 64'd1);
    clear_obs();
    s_val = 1'b1; s_seg = rand_seg(); s_last = 1'b1;
    step();
    s_val = 1'b0; s_last = 1'b0;
    wait_done("rst_job", 1'b0);
    check_eq("rst_job_issues", 64'(obs_issue_edge.size()), 64'd1);

    // randomized jobs with random valid gaps and random hits
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(1, 14);
      idx = 0; k = 0;
      while (idx < n && k < 400) begin
        s_val = ($urandom_range(0, 3) != 0);
        s_seg = rand_seg();
        s_last = (idx == n - 1);
        cd_out_val = ($urandom_range(0, 4) == 0);
        cd_lineID = 8'($urandom_range(0, 255));
        step();
        if (m_accepted) idx++;
        k++;
      end
      s_val = 1'b0; s_last = 1'b0;
      check_eq("rnd_accepts", 64'(idx), 64'(n));
      wait_done("rnd", 1'b1);
      pause = $urandom_range(0, 3);
      for (int i = 0; i < pause; i++) step();
    end

    // hit counter saturation
    cd_out_val = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      cd_lineID = 8'(i);
      step();
    end
    cd_out_val = 1'b0;
    check_eq("sat_hit_cnt", 64'(hit_cnt), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
